// File: rtl/spi_frame_slave_if.sv
// Bus bundle between the SPI frame slave, its SPI master pins and the register bank.
// The slave modport is the design side; the master modport drives pins and bank data.
interface spi_frame_slave_if #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
);
  logic              spi_cs_n;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso;
  logic [ADDR_W-1:0] reg_addr;
  logic [REG_W-1:0]  reg_data_i;
  logic [REG_W-1:0]  reg_data_o;
  logic              reg_data_o_vld;
  logic [REG_W-1:0]  status;
  logic              frame_abort;

  modport slave (
    input  spi_cs_n, spi_clk, spi_mosi, reg_data_i, status,
    output spi_miso, reg_addr, reg_data_o, reg_data_o_vld, frame_abort
  );

  modport master (
    output spi_cs_n, spi_clk, spi_mosi, reg_data_i, status,
    input  spi_miso, reg_addr, reg_data_o, reg_data_o_vld, frame_abort
  );
endinterface

// File: rtl/spi_frame_slave.sv
// Oversampled SPI mode-0 slave: command byte + REG_W data bits become register writes/reads.
// Define SPI_FRAME_STATUS_EN to shift status[7:0] out on MISO during the command byte.
module spi_frame_slave #(
  parameter int ADDR_W      = 3,
  parameter int REG_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  spi_frame_slave_if.slave bus
);
  localparam int CNT_W = $clog2(REG_W + 1);

  typedef enum logic [2:0] {IDLE, CMD, LOAD, DATA, DONE} fsmState_e;

  logic [SYNC_STAGES-1:0] csSync_q;
  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] mosiSync_q;
  logic                   csPrev_q;
  logic                   sclkPrev_q;

  logic csFall;
  logic csRise;
  logic sclkRise;
  logic sclkFall;
  logic mosiBit;

  fsmState_e         state_q;
  logic [CNT_W-1:0]  bitCnt_q;
  logic [6:0]        cmdShift_q;
  logic [REG_W-2:0]  rxShift_q;
  logic [REG_W-2:0]  txShift_q;
  logic              isWrite_q;
  logic              miso_q;
  logic [ADDR_W-1:0] regAddr_q;
  logic [REG_W-1:0]  regDataOut_q;
  logic              regDataVld_q;
  logic              frameAbort_q;
`ifdef SPI_FRAME_STATUS_EN
  logic [6:0]        stsShift_q;
`endif

  logic [7:0]        cmd_d;
  logic [REG_W-1:0]  rx_d;
  logic [REG_W-1:0]  loadVal_d;
  logic              unusedStatus;

  always_ff @(posedge clk) begin
    if (rst) begin
      csSync_q   <= '0;
      sclkSync_q <= '0;
      mosiSync_q <= '0;
      csPrev_q   <= 1'b0;
      sclkPrev_q <= 1'b0;
    end else begin
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], bus.spi_clk};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      csPrev_q   <= csSync_q[SYNC_STAGES-1];
      sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
    end
  end

  assign csFall   = csPrev_q & ~csSync_q[SYNC_STAGES-1];
  assign csRise   = ~csPrev_q & csSync_q[SYNC_STAGES-1];
  assign sclkRise = ~sclkPrev_q & sclkSync_q[SYNC_STAGES-1];
  assign sclkFall = sclkPrev_q & ~sclkSync_q[SYNC_STAGES-1];
  assign mosiBit  = mosiSync_q[SYNC_STAGES-1];

  assign cmd_d     = {cmdShift_q, mosiBit};
  assign rx_d      = {rxShift_q, mosiBit};
  assign loadVal_d = isWrite_q ? '0 : bus.reg_data_i;

  // The fall that ends the last command bit lands in DATA with bitCnt_q still 0; it must not
  // shift, otherwise the data MSB would leave MISO before the master samples it.
  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      cmdShift_q   <= '0;
      rxShift_q    <= '0;
      txShift_q    <= '0;
      isWrite_q    <= 1'b0;
      miso_q       <= 1'b0;
      regAddr_q    <= '0;
      regDataOut_q <= '0;
      regDataVld_q <= 1'b0;
      frameAbort_q <= 1'b0;
`ifdef SPI_FRAME_STATUS_EN
      stsShift_q   <= '0;
`endif
    end else begin
      regDataVld_q <= 1'b0;
      frameAbort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (csFall) begin
            state_q    <= CMD;
            bitCnt_q   <= '0;
            cmdShift_q <= '0;
            rxShift_q  <= '0;
            txShift_q  <= '0;
`ifdef SPI_FRAME_STATUS_EN
            miso_q     <= bus.status[7];
            stsShift_q <= bus.status[6:0];
`endif
          end
        end

        CMD: begin
          if (csRise) begin
            state_q      <= IDLE;
            frameAbort_q <= 1'b1;
            miso_q       <= 1'b0;
          end else if (sclkRise) begin
            cmdShift_q <= cmd_d[6:0];
            if (bitCnt_q == CNT_W'(7)) begin
              isWrite_q <= cmd_d[7];
              regAddr_q <= cmd_d[ADDR_W-1:0];
              miso_q    <= 1'b0;
              state_q   <= LOAD;
            end else begin
              bitCnt_q <= bitCnt_q + CNT_W'(1);
            end
          end
`ifdef SPI_FRAME_STATUS_EN
          else if (sclkFall && (bitCnt_q != '0)) begin
            miso_q     <= stsShift_q[6];
            stsShift_q <= {stsShift_q[5:0], 1'b0};
          end
`endif
        end

        LOAD: begin
          if (csRise) begin
            state_q      <= IDLE;
            frameAbort_q <= 1'b1;
            miso_q       <= 1'b0;
          end else begin
            txShift_q <= loadVal_d[REG_W-2:0];
            miso_q    <= loadVal_d[REG_W-1];
            bitCnt_q  <= '0;
            state_q   <= DATA;
          end
        end

        DATA: begin
          if (sclkRise && (bitCnt_q == CNT_W'(REG_W - 1))) begin
            if (isWrite_q) begin
              regDataOut_q <= rx_d;
              regDataVld_q <= 1'b1;
            end
            miso_q  <= 1'b0;
            state_q <= csRise ? IDLE : DONE;
          end else if (csRise) begin
            state_q      <= IDLE;
            frameAbort_q <= 1'b1;
            miso_q       <= 1'b0;
          end else if (sclkRise) begin
            rxShift_q <= rx_d[REG_W-2:0];
            bitCnt_q  <= bitCnt_q + CNT_W'(1);
          end else if (sclkFall && (bitCnt_q != '0)) begin
            miso_q    <= txShift_q[REG_W-2];
            txShift_q <= {txShift_q[REG_W-3:0], 1'b0};
          end
        end

        DONE: begin
          miso_q <= 1'b0;
          if (csRise) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          miso_q  <= 1'b0;
        end
      endcase
    end
  end

  assign unusedStatus = ^bus.status;

  assign bus.spi_miso       = miso_q;
  assign bus.reg_addr       = regAddr_q;
  assign bus.reg_data_o     = regDataOut_q;
  assign bus.reg_data_o_vld = regDataVld_q;
  assign bus.frame_abort    = frameAbort_q;
endmodule

// File: tb/tb_spi_frame_slave.sv
// Randomized SPI frames against spi_frame_slave; strobes, aborts and MISO bytes are scoreboarded
// against a bank model. Define SPI_FRAME_STATUS_EN consistently with the RTL build.
module tb_spi_frame_slave;
  localparam int HALF = 6;
`ifdef SPI_FRAME_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ena;

  always #5 clk = ~clk;

  spi_frame_slave_if #(.ADDR_W(3), .REG_W(8)) bus ();

  spi_frame_slave #(.ADDR_W(3), .REG_W(8), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus.slave)
  );

  // Read-only bank: contents fixed at start, so a read returns bankMem[address].
  logic [7:0] bankMem [8];
  assign bus.reg_data_i = bankMem[bus.reg_addr];

  typedef struct packed {
    logic       isAbort;
    logic [2:0] addr;
    logic [7:0] data;
  } event_t;

  typedef struct packed {
    logic [7:0] cmdMiso;
    logic [7:0] dataMiso;
    logic       extraMiso;
  } miso_t;

  event_t expEvQ[$];
  miso_t  expMisoQ[$];
  miso_t  obsMisoQ[$];
  event_t monEv;
  miso_t  monObs;
  miso_t  monExp;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_miso"}, 32'(bus.spi_miso), 32'd0);
    checkOutput({tag, "_addr"}, 32'(bus.reg_addr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(bus.reg_data_o), 32'd0);
    checkOutput({tag, "_vld"}, 32'(bus.reg_data_o_vld), 32'd0);
    checkOutput({tag, "_abort"}, 32'(bus.frame_abort), 32'd0);
  endtask

  // Mode-0 master: MOSI set while SCLK low, MISO sampled just before each rise.
  task automatic shiftBits(input logic [15:0] frame, input int nBits, output logic [15:0] seen);
    seen = '0;
    for (int b = 0; b < nBits; b++) begin
      bus.spi_mosi = frame[15-b];
      idle(HALF);
      seen[15-b] = bus.spi_miso;
      bus.spi_clk = 1'b1;
      idle(HALF);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] stat,
                               input int abortBit, input int extraPulses);
    logic [15:0] seen;
    logic        extraSeen;
    event_t      ev;
    miso_t       em;
    miso_t       om;
    int          nBits;
    nBits     = (abortBit >= 0) ? abortBit : 16;
    extraSeen = 1'b0;
    bus.status = stat;
    if (abortBit >= 0) begin
      ev = '{isAbort: 1'b1, addr: 3'd0, data: 8'd0};
      expEvQ.push_back(ev);
    end else begin
      if (cmd[7]) begin
        ev = '{isAbort: 1'b0, addr: cmd[2:0], data: data};
        expEvQ.push_back(ev);
      end
      em.cmdMiso   = STATUS_EN ? stat : 8'h00;
      em.dataMiso  = cmd[7] ? 8'h00 : bankMem[cmd[2:0]];
      em.extraMiso = 1'b0;
      expMisoQ.push_back(em);
    end
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    idle(2 * HALF);
    shiftBits({cmd, data}, nBits, seen);
    for (int e = 0; e < extraPulses; e++) begin
      bus.spi_mosi = 1'($urandom);
      idle(HALF);
      extraSeen = extraSeen | bus.spi_miso;
      bus.spi_clk = 1'b1;
      idle(HALF);
      bus.spi_clk = 1'b0;
    end
    idle(HALF);
    bus.spi_cs_n = 1'b1;
    idle(3 * HALF);
    if (abortBit < 0) begin
      om = '{cmdMiso: seen[15:8], dataMiso: seen[7:0], extraMiso: extraSeen};
      obsMisoQ.push_back(om);
    end
  endtask

  // Write frame cut after four data bits by rst or by ena; outputs must be back at reset values.
  task automatic disruptDataPhase(input bit useRst);
    logic [15:0] seen;
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    idle(2 * HALF);
    shiftBits({8'h84, 8'($urandom)}, 12, seen);
    if (useRst) rst = 1'b1;
    else        ena = 1'b0;
    @(negedge clk);
    checkResetOutputs(useRst ? "rst_mid" : "ena_mid");
    rst = 1'b0;
    idle(4);
    ena = 1'b1;
    bus.spi_cs_n = 1'b1;
    idle(3 * HALF);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT strobes, aborts or a frame's MISO is captured.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.reg_data_o_vld === 1'b1 || bus.frame_abort === 1'b1) begin
        if (expEvQ.size() == 0) begin
          checkOutput("unexpected_event", 32'({bus.reg_data_o_vld, bus.frame_abort}), 32'd0);
        end else begin
          monEv = expEvQ.pop_front();
          checkOutput("event_kind", 32'({bus.reg_data_o_vld, bus.frame_abort}),
                      monEv.isAbort ? 32'd1 : 32'd2);
          if (!monEv.isAbort) begin
            checkOutput("wr_addr", 32'(bus.reg_addr), 32'(monEv.addr));
            checkOutput("wr_data", 32'(bus.reg_data_o), 32'(monEv.data));
          end
        end
      end
      while (obsMisoQ.size() > 0) begin
        monObs = obsMisoQ.pop_front();
        if (expMisoQ.size() == 0) begin
          checkOutput("unexpected_miso", 32'd1, 32'd0);
        end else begin
          monExp = expMisoQ.pop_front();
          checkOutput("miso_cmd", 32'(monObs.cmdMiso), 32'(monExp.cmdMiso));
          checkOutput("miso_data", 32'(monObs.dataMiso), 32'(monExp.dataMiso));
          checkOutput("miso_extra", 32'(monObs.extraMiso), 32'(monExp.extraMiso));
        end
      end
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    logic [7:0] rCmd;
    logic [7:0] rData;
    logic [7:0] rStat;
    int         rAbort;
    int         rExtra;
    rst          = 1'b1;
    ena          = 1'b1;
    bus.spi_cs_n = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.status   = 8'h00;
    for (int i = 0; i < 8; i++) bankMem[i] = 8'($urandom);
    bankMem[3] = 8'h3C;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    idle(10);

    applyStimulus(8'h85, 8'hA5, 8'h5A, -1, 0);
    applyStimulus(8'h03, 8'h00, 8'h96, -1, 0);
    applyStimulus(8'h82, 8'h5F, 8'h00, 12, 0);
    applyStimulus(8'h81, 8'h11, 8'h00, -1, 0);
    applyStimulus(8'hC6, 8'h77, 8'hE1, -1, 20);
    applyStimulus(8'h07, 8'h00, 8'h00, 3, 0);
    applyStimulus(8'h80, 8'h00, 8'h00, 8, 0);
    disruptDataPhase(1'b1);
    applyStimulus(8'h87, 8'h3E, 8'h24, -1, 0);
    disruptDataPhase(1'b0);
    applyStimulus(8'h02, 8'hFF, 8'h81, -1, 0);

    for (int n = 0; n < 36; n++) begin
      rCmd   = 8'($urandom);
      rData  = 8'($urandom);
      rStat  = 8'($urandom);
      rAbort = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : -1;
      rExtra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      applyStimulus(rCmd, rData, rStat, rAbort, rExtra);
    end

    idle(20);
    checkOutput("events_pending", 32'(expEvQ.size()), 32'd0);
    checkOutput("miso_pending", 32'(expMisoQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_frame_slave.md
# spi_frame_slave

Oversampled SPI mode-0 slave front end that converts serial frames into register-bank accesses. It sits directly upstream of the configuration register bank. Writes are delivered as a one-cycle address/data strobe. Reads fetch the addressed register and shift it back on MISO. All SPI pins are treated as asynchronous and are synchronised into the system clock domain.

## Interface
Parameters:
- ADDR_W, 3, register address width; legal range 1..7.
- REG_W, 8, register data width; legal range 8..32.
- SYNC_STAGES, 2, synchroniser depth on spi_cs_n, spi_clk and spi_mosi; minimum 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  block enable; low forces IDLE and ignores SPI activity.
- spi_cs_n  in  1  chip select, active low, asynchronous.
- spi_clk  in  1  SPI clock, asynchronous, CPOL=0.
- spi_mosi  in  1  serial data in, asynchronous.
- spi_miso  out  1  serial data out; registered.
- reg_addr  out  ADDR_W  decoded address; registered.
- reg_data_i  in  REG_W  read data for reg_addr; combinational from the bank.
- reg_data_o  out  REG_W  write data; registered.
- reg_data_o_vld  out  1  one-cycle write strobe.
- status  in  REG_W  status word shifted out during the command phase.
- frame_abort  out  1  one-cycle pulse when CS deasserts mid-frame.

## Operation
- Edge detection runs on the synchronised signals: CS fall/rise, SCLK rise (sample MOSI) and SCLK fall (shift MISO).
- Frame layout:
  - Command byte, 8 bits, MSB first. Bit 7 = 1 is a write, 0 is a read. Bits [ADDR_W-1:0] are the address; the remaining bits are ignored.
  - Data phase follows, REG_W bits, MSB first.
- FSM states: IDLE, CMD, LOAD, DATA, DONE.
  - IDLE → CMD on CS fall (ena=1). Bit counter clears to 0.
  - CMD: each SCLK rise shifts MOSI into the command shifter. The 8th rise latches rw and updates reg_addr, then moves to LOAD.
  - LOAD (1 cycle): tx shifter ← reg_data_i when the command is a read, else 0. Then DATA with the counter at 0.
  - DATA: each SCLK rise shifts MOSI into the rx shifter. Each SCLK fall shifts the tx shifter left.
    - On the REG_W-th rise: for a write, reg_data_o ← rx value and reg_data_o_vld=1 next cycle; for a read, no strobe. Then DONE.
  - DONE: SCLK is ignored until CS rises, then IDLE.
- CS rise in CMD, LOAD or DATA: return to IDLE, frame_abort=1 for one cycle, no write strobe, reg_addr keeps its last value.
- CS rise in DONE or IDLE: no abort pulse.
- spi_miso:
  - DATA: tx shifter MSB.
  - CMD: see Configuration.
  - IDLE, LOAD, DONE: 0.
- ena low in any state: IDLE next cycle, no strobe, no abort pulse.
- Extra SCLK edges in DONE must not wrap the counter or start a new command. A new frame requires a CS fall.

## Timing
- Reset values: spi_miso=0, reg_addr=0, reg_data_o=0, reg_data_o_vld=0, frame_abort=0, state IDLE, all shifters and counters 0.
- Input-to-edge-detect latency is SYNC_STAGES+1 clk cycles, identical for all three pins.
- f_clk must be ≥ 8·f_sclk. Each SCLK half-period is ≥ 4 clk.
- Write strobe: reg_data_o_vld is high exactly 1 cycle, 1 cycle after the last data rise is detected. reg_addr and reg_data_o are stable from that cycle until the next frame's command completes.
- Read: reg_data_i is sampled in LOAD, 1 cycle after reg_addr updates. The MSB is valid on MISO before the first data-phase SCLK fall is detected.
- Write strobe and CS rise detected in the same cycle: the strobe is still issued, with no abort.

## Configuration
- Macro SPI_FRAME_STATUS_EN:
  - Defined: status[7:0] is captured on CS fall and shifted out MSB first on MISO during CMD, changing on each SCLK fall. Bit 7 is presented immediately after the CS-fall detect.
  - Undefined: MISO is 0 throughout CMD and the status port is unused.

## Test plan
- Write frame 0x85, 0xA5 (ADDR_W=3, REG_W=8) → one reg_data_o_vld pulse with reg_addr=5, reg_data_o=0xA5; no frame_abort.
- Read frame 0x03 with the bank returning 0x3C for address 3 → MISO data phase = 0,0,1,1,1,1,0,0; no strobe.
- With SPI_FRAME_STATUS_EN defined and status=0x96 → MISO during the command byte = 1,0,0,1,0,1,1,0. Undefined → all 0.
- CS raised after 4 data bits of write 0x82,… → frame_abort one pulse, no strobe, next write 0x81,0x11 gives reg_addr=1, reg_data_o=0x11.
- 20 extra SCLK pulses after a complete write frame → exactly one strobe, state DONE until CS rises.
- rst asserted, or ena dropped, mid data phase → all outputs at reset values next cycle; the following full frame completes normally.
